// File: rtl/mc6502_vector_responder.sv
// Read-port responder for the 6502 interrupt logic: serves the six vector bytes at $FFFA-$FFFF
// from programmable registers and forwards every other read to external memory with a timeout guard.
module mc6502_vector_responder #(
    parameter logic [15:0] NMI_VEC  = 16'hE000,
    parameter logic [15:0] RST_VEC  = 16'hE000,
    parameter logic [15:0] IRQ_VEC  = 16'hE000,
    parameter int          TIMEOUT  = 16,
    parameter logic [7:0]  TMO_DATA = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic [15:0] il2mc_addr,
    input  logic        il2mc_read,
    output logic [7:0]  mc2il_data,
    output logic        mc2il_valid,
    output logic        mc2il_busy,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_sel,
    input  logic [7:0]  cfg_data,
    output logic [15:0] ext_addr,
    output logic        ext_req,
    input  logic        ext_ack,
    input  logic [7:0]  ext_data,
    output logic        err_timeout,
    input  logic        err_clr
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_RESP
    } state_t;

    // Byte i of the packed vector file is address $FFFA+i (low byte of each vector first).
    function automatic logic [5:0][7:0] vec_reset_value();
        return {IRQ_VEC, RST_VEC, NMI_VEC};
    endfunction

    function automatic logic is_vector(input logic [15:0] addr);
        return addr >= 16'hFFFA;
    endfunction

    function automatic logic [2:0] vec_index(input logic [15:0] addr);
        return addr[2:0] - 3'd2;
    endfunction

    state_t           state_q, state_d;
    logic [5:0][7:0]  vec_q, vec_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [15:0]      ext_addr_q, ext_addr_d;
    logic             ext_req_q, ext_req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             tmo_hit;

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ext_addr_d = ext_addr_q;
        ext_req_d  = ext_req_q;
        cnt_d      = cnt_q;
        tmo_hit    = 1'b0;

        if (cfg_we && (cfg_sel <= 3'd5)) begin
            vec_d[cfg_sel] = cfg_data;
        end

        case (state_q)
            S_IDLE: begin
                if (il2mc_read) begin
                    if (is_vector(il2mc_addr)) begin
                        // vec_q is the pre-write value, so a same-edge config write is not visible yet.
                        data_d  = vec_q[vec_index(il2mc_addr)];
                        valid_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        ext_addr_d = il2mc_addr;
                        ext_req_d  = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_EXT;
                    end
                end
            end
            S_EXT: begin
                if (ext_ack) begin
                    data_d    = ext_data;
                    ext_req_d = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d    = TMO_DATA;
                    ext_req_d = 1'b0;
                    valid_d   = 1'b1;
                    tmo_hit   = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                ext_req_d = 1'b0;
            end
        endcase

        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (tmo_hit) begin
            err_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_x) begin
            state_q    <= S_IDLE;
            vec_q      <= vec_reset_value();
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ext_addr_q <= 16'h0000;
            ext_req_q  <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            ext_addr_q <= ext_addr_d;
            ext_req_q  <= ext_req_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign mc2il_data  = data_q;
    assign mc2il_valid = valid_q;
    assign mc2il_busy  = busy_q;
    assign ext_addr    = ext_addr_q;
    assign ext_req     = ext_req_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_mc6502_vector_responder.sv
// Bench for mc6502_vector_responder: directed vector table, hand-written reset/error sequences,
// then randomized reads checked against a byte-array model of the vector file and timeout rules.
module tb_mc6502_vector_responder;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_x;
    logic [15:0] il2mc_addr;
    logic        il2mc_read;
    logic [7:0]  mc2il_data;
    logic        mc2il_valid;
    logic        mc2il_busy;
    logic        cfg_we;
    logic [2:0]  cfg_sel;
    logic [7:0]  cfg_data;
    logic [15:0] ext_addr;
    logic        ext_req;
    logic        ext_ack;
    logic [7:0]  ext_data;
    logic        err_timeout;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    logic [7:0] vec_m [6];
    logic       err_m;
    logic [7:0] last_data;

    typedef struct {
        bit          rd;
        logic [15:0] addr;
        int          dly;
        logic [7:0]  xd;
        bit          wr;
        logic [2:0]  sel;
        logic [7:0]  wd;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl [15];

    mc6502_vector_responder #(
        .NMI_VEC (16'hE000),
        .RST_VEC (16'hE000),
        .IRQ_VEC (16'hE000),
        .TIMEOUT (TMO),
        .TMO_DATA(8'hFF)
    ) dut (
        .clk        (clk),
        .rst_x      (rst_x),
        .il2mc_addr (il2mc_addr),
        .il2mc_read (il2mc_read),
        .mc2il_data (mc2il_data),
        .mc2il_valid(mc2il_valid),
        .mc2il_busy (mc2il_busy),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .ext_addr   (ext_addr),
        .ext_req    (ext_req),
        .ext_ack    (ext_ack),
        .ext_data   (ext_data),
        .err_timeout(err_timeout),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) vec_m[i] = (i % 2 == 0) ? 8'h00 : 8'hE0;
        err_m     = 1'b0;
        last_data = 8'h00;
    endtask

    task automatic cfg_write(input logic [2:0] sel, input logic [7:0] wd);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_data = wd;
        tick();
        cfg_we = 1'b0;
        if (sel < 3'd6) vec_m[sel] = wd;
    endtask

    // One complete read: accept, wait for the strobe (bounded), then the return-to-idle cycle.
    task automatic txn(input logic [15:0] a, input int dly, input logic [7:0] xd,
                       input bit wr, input logic [2:0] sel, input logic [7:0] wd,
                       input logic [7:0] exp, input int clr_at, input bit noise, input string tag);
        bit vec_hit, tmo, got, clr_seen, addr_bad;
        int req_cyc;
        vec_hit = (a >= 16'hFFFA);
        tmo     = !vec_hit && (dly >= TMO);
        chk({tag, ".idle_before"}, mc2il_busy, 1'b0);
        il2mc_addr = a;
        il2mc_read = 1'b1;
        cfg_we     = wr;
        cfg_sel    = sel;
        cfg_data   = wd;
        tick();
        il2mc_read = 1'b0;
        cfg_we     = 1'b0;
        if (wr && sel < 3'd6) vec_m[sel] = wd;
        got = 0; clr_seen = 0; addr_bad = 0; req_cyc = 0;
        for (int k = 0; k < TMO + 4 && !got; k++) begin
            if (mc2il_valid) begin
                got = 1;
            end else begin
                if (ext_req) req_cyc++;
                if (!ext_req || ext_addr !== a) addr_bad = 1;
                ext_ack  = (k == dly);
                ext_data = (k == dly) ? xd : 8'($urandom);
                err_clr  = (k == clr_at);
                if (k == clr_at) clr_seen = 1;
                if (noise) begin
                    il2mc_read = 1'($urandom);
                    il2mc_addr = 16'($urandom);
                end
                tick();
                ext_ack    = 1'b0;
                err_clr    = 1'b0;
                il2mc_read = 1'b0;
            end
        end
        if (tmo) err_m = 1'b1;
        else if (clr_seen) err_m = 1'b0;
        chk({tag, ".valid"}, got, 1'b1);
        chk({tag, ".data"}, mc2il_data, exp);
        chk({tag, ".busy_in_resp"}, mc2il_busy, 1'b1);
        chk({tag, ".req_dropped"}, ext_req, 1'b0);
        chk({tag, ".req_cycles"}, req_cyc, vec_hit ? 0 : (tmo ? TMO : dly + 1));
        chk({tag, ".ext_addr_held"}, addr_bad, 1'b0);
        chk({tag, ".err"}, err_timeout, err_m);
        if (noise) begin
            il2mc_read = 1'b1;
            il2mc_addr = 16'hFFFA + 16'($urandom_range(0, 5));
            ext_ack    = 1'b1;
        end
        tick();
        il2mc_read = 1'b0;
        ext_ack    = 1'b0;
        chk({tag, ".valid_pulse"}, mc2il_valid, 1'b0);
        chk({tag, ".busy_clear"}, mc2il_busy, 1'b0);
        chk({tag, ".data_held"}, mc2il_data, exp);
        last_data = exp;
    endtask

    function automatic vec_t mk(bit rd, logic [15:0] addr, int dly, logic [7:0] xd,
                                bit wr, logic [2:0] sel, logic [7:0] wd, logic [7:0] exp);
        vec_t v;
        v.rd = rd; v.addr = addr; v.dly = dly; v.xd = xd;
        v.wr = wr; v.sel = sel; v.wd = wd; v.exp = exp;
        return v;
    endfunction

    initial begin
        logic [15:0] a;
        logic [7:0]  xd, wd, exp;
        int          dly, clr_at;
        bit          wr;
        logic [2:0]  sel;

        tbl[0]  = mk(1, 16'hFFFC, 0,  8'h00, 0, 3'd0, 8'h00, 8'h00);
        tbl[1]  = mk(1, 16'hFFFD, 0,  8'h00, 0, 3'd0, 8'h00, 8'hE0);
        tbl[2]  = mk(0, 16'h0000, 0,  8'h00, 1, 3'd4, 8'h89, 8'h00);
        tbl[3]  = mk(1, 16'hFFFE, 0,  8'h00, 0, 3'd0, 8'h00, 8'h89);
        tbl[4]  = mk(1, 16'hFFFF, 0,  8'h00, 1, 3'd5, 8'h12, 8'hE0);
        tbl[5]  = mk(1, 16'hFFFF, 0,  8'h00, 0, 3'd0, 8'h00, 8'h12);
        tbl[6]  = mk(0, 16'h0000, 0,  8'h00, 1, 3'd6, 8'h33, 8'h00);
        tbl[7]  = mk(0, 16'h0000, 0,  8'h00, 1, 3'd7, 8'h44, 8'h00);
        tbl[8]  = mk(1, 16'hFFFA, 0,  8'h00, 0, 3'd0, 8'h00, 8'h00);
        tbl[9]  = mk(1, 16'hFFFB, 0,  8'h00, 0, 3'd0, 8'h00, 8'hE0);
        tbl[10] = mk(1, 16'h1234, 3,  8'h5A, 0, 3'd0, 8'h00, 8'h5A);
        tbl[11] = mk(1, 16'hFFF9, 0,  8'h77, 0, 3'd0, 8'h00, 8'h77);
        tbl[12] = mk(1, 16'h4000, 15, 8'h3C, 0, 3'd0, 8'h00, 8'h3C);
        tbl[13] = mk(1, 16'h2000, 99, 8'h00, 0, 3'd0, 8'h00, 8'hFF);
        tbl[14] = mk(1, 16'h0000, 1,  8'h00, 0, 3'd0, 8'h00, 8'h00);

        rst_x = 1'b0; il2mc_addr = '0; il2mc_read = 0; cfg_we = 0; cfg_sel = '0;
        cfg_data = '0; ext_ack = 0; ext_data = '0; err_clr = 0;
        model_reset();
        tick();
        tick();
        rst_x = 1'b1;
        chk("reset.data", mc2il_data, 8'h00);
        chk("reset.valid", mc2il_valid, 1'b0);
        chk("reset.busy", mc2il_busy, 1'b0);
        chk("reset.req", ext_req, 1'b0);
        chk("reset.addr", ext_addr, 16'h0000);
        chk("reset.err", err_timeout, 1'b0);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rd)
                txn(tbl[i].addr, tbl[i].dly, tbl[i].xd, tbl[i].wr, tbl[i].sel, tbl[i].wd,
                    tbl[i].exp, -1, 0, $sformatf("tbl%0d", i));
            else
                cfg_write(tbl[i].sel, tbl[i].wd);
        end

        // Sticky error: clear alone, then a clear landing on the timeout edge loses to the set.
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        err_m   = 1'b0;
        chk("err_clr.alone", err_timeout, 1'b0);
        txn(16'h2000, 99, 8'h00, 0, 3'd0, 8'h00, 8'hFF, TMO - 1, 0, "clr_vs_tmo");
        txn(16'h2002, 8, 8'hC3, 0, 3'd0, 8'h00, 8'hC3, 5, 0, "clr_mid_ack");

        // Stray ack while idle must not produce a response.
        ext_ack  = 1'b1;
        ext_data = 8'h55;
        tick();
        ext_ack = 1'b0;
        chk("stray_ack.valid", mc2il_valid, 1'b0);
        chk("stray_ack.busy", mc2il_busy, 1'b0);
        chk("stray_ack.data", mc2il_data, last_data);

        // Reset while an external read is waiting: aborts with no response, vectors reload.
        il2mc_addr = 16'h3000;
        il2mc_read = 1'b1;
        tick();
        il2mc_read = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("rst_mid.req_before", ext_req, 1'b1);
        rst_x = 1'b0;
        tick();
        rst_x = 1'b1;
        model_reset();
        chk("rst_mid.req", ext_req, 1'b0);
        chk("rst_mid.busy", mc2il_busy, 1'b0);
        chk("rst_mid.valid", mc2il_valid, 1'b0);
        chk("rst_mid.data", mc2il_data, 8'h00);
        chk("rst_mid.err", err_timeout, 1'b0);
        ext_ack = 1'b1;
        tick();
        ext_ack = 1'b0;
        chk("rst_mid.no_late_valid", mc2il_valid, 1'b0);
        txn(16'hFFFE, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, -1, 0, "rst_mid.reload");

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) cfg_write(3'($urandom), 8'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                err_m   = 1'b0;
                chk("rnd.err_clr", err_timeout, 1'b0);
            end
            if ($urandom_range(0, 7) == 0) begin
                ext_ack = 1'b1;
                tick();
                ext_ack = 1'b0;
                chk("rnd.stray_ack", mc2il_valid, 1'b0);
            end
            a      = $urandom_range(0, 1) ? 16'hFFFA + 16'($urandom_range(0, 5)) : 16'($urandom);
            dly    = $urandom_range(0, 19);
            xd     = 8'($urandom);
            wr     = ($urandom_range(0, 3) == 0);
            sel    = 3'($urandom);
            wd     = 8'($urandom);
            clr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 17)) : -1;
            if (a >= 16'hFFFA) exp = vec_m[int'(a) - 'hFFFA];
            else if (dly >= TMO) exp = 8'hFF;
            else exp = xd;
            txn(a, dly, xd, wr, sel, wd, exp, clr_at, 1'($urandom), $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
